ps2_zx_keymatrix: RTL and testbench

- Upstream feeder of the ULA port-0xFE read path: receives PS/2 set-2 frames and maintains the 8x5 ZX Spectrum key matrix.
- Returns the active-low column data for the half-rows selected by the high address byte.
- Also exports F1..F11 press flags and modifier states for the on-screen menu and reset logic.
- Runs on the 14 MHz ULA clock.

---
 rtl/ps2_zx_keymatrix.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_ps2_zx_keymatrix.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_zx_keymatrix.sv
// ps2_zx_keymatrix: PS/2 set-2 receiver feeding the 8x5 ZX Spectrum key matrix.
// Conditions PS2_CLK/PS2_DAT and receives 11-bit frames. Decodes make/break
// (E0/F0 prefixes) into the matrix, F1..F11 flags and modifier states.
// key_data is the active-low AND of every half-row selected by addr[15:8].
// Optional build macro: PS2_CURSOR_EN. When defined, arrows and Backspace
// produce CAPS SHIFT plus a digit key.
module ps2_zx_keymatrix #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 14000
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    input  logic [15:0] addr,
    output logic [4:0]  key_data,
    output logic [10:0] Fn,
    output logic [2:0]  mod
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    // Indices into hold_reg. These keys have a left/right or main/keypad twin,
    // so each one is tracked on its own and the pair is ORed.
    localparam int H_LSHIFT = 0;
    localparam int H_RSHIFT = 1;
    localparam int H_LCTRL  = 2;
    localparam int H_RCTRL  = 3;
    localparam int H_LALT   = 4;
    localparam int H_RALT   = 5;
    localparam int H_ENTER  = 6;
    localparam int H_KPENT  = 7;

    logic             clk_s1_reg, clk_s2_reg, dat_s1_reg, dat_s2_reg;
    logic             filt_reg;
    logic [FCW-1:0]   fcnt_reg;
    logic             fall;

    rx_state_t        state_reg;
    logic [2:0]       bitcnt_reg;
    logic [7:0]       shift_reg;
    logic             par_reg;
    logic [WDW-1:0]   wd_reg;
    logic             byte_valid_reg;
    logic [7:0]       byte_reg;

    logic             ext_reg, rel_reg;
    logic [7:0][4:0]  matrix_reg;
    logic [10:0]      fn_reg;
    logic [7:0]       hold_reg;
`ifdef PS2_CURSOR_EN
    // {bksp, right, up, down, left}: shadow holds for the cursor keys.
    logic [4:0]       cur_reg;
`endif

    logic [8:0]       code9;
    logic [5:0]       map_rc;
    logic [3:0]       fn_idx;
    logic [7:0][4:0]  eff;
    logic [7:0][4:0]  row_term;
    logic             unused_addr;

    assign unused_addr = ^addr[7:0];

    // Synchronise both lines and debounce the clock with a saturating counter.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            clk_s1_reg <= 1'b1;
            clk_s2_reg <= 1'b1;
            dat_s1_reg <= 1'b1;
            dat_s2_reg <= 1'b1;
            filt_reg   <= 1'b1;
            fcnt_reg   <= '0;
        end else begin
            clk_s1_reg <= PS2_CLK;
            clk_s2_reg <= clk_s1_reg;
            dat_s1_reg <= PS2_DAT;
            dat_s2_reg <= dat_s1_reg;
            if (clk_s2_reg == filt_reg) begin
                fcnt_reg <= '0;
            end else if (fcnt_reg == FCW'(FILTER_LEN - 1)) begin
                filt_reg <= clk_s2_reg;
                fcnt_reg <= '0;
            end else begin
                fcnt_reg <= fcnt_reg + 1'b1;
            end
        end
    end

    // The filtered clock is about to go 1->0; data is sampled in this cycle.
    assign fall = filt_reg && !clk_s2_reg && (fcnt_reg == FCW'(FILTER_LEN - 1));

    // Frame receiver with a watchdog that abandons stalled frames.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_reg      <= IDLE;
            bitcnt_reg     <= '0;
            shift_reg      <= '0;
            par_reg        <= 1'b0;
            wd_reg         <= '0;
            byte_valid_reg <= 1'b0;
            byte_reg       <= '0;
        end else begin
            byte_valid_reg <= 1'b0;
            if (fall) begin
                // An edge always beats a simultaneous timeout.
                wd_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (!dat_s2_reg) begin
                            state_reg  <= DATA;
                            bitcnt_reg <= '0;
                        end
                    end
                    DATA: begin
                        shift_reg  <= {dat_s2_reg, shift_reg[7:1]};
                        bitcnt_reg <= bitcnt_reg + 1'b1;
                        if (bitcnt_reg == 3'd7) state_reg <= PARITY;
                    end
                    PARITY: begin
                        par_reg   <= dat_s2_reg;
                        state_reg <= STOP;
                    end
                    default: begin
                        if (dat_s2_reg && (^{shift_reg, par_reg})) begin
                            byte_valid_reg <= 1'b1;
                            byte_reg       <= shift_reg;
                        end
                        state_reg <= IDLE;
                    end
                endcase
            end else if (state_reg != IDLE) begin
                if (wd_reg == WDW'(TIMEOUT_CYCLES)) begin
                    state_reg <= IDLE;
                    wd_reg    <= '0;
                end else begin
                    wd_reg <= wd_reg + 1'b1;
                end
            end else begin
                wd_reg <= '0;
            end
        end
    end

    assign code9 = {ext_reg, byte_reg};

    // Scan code to matrix position (octal {row, col}) and to F-key index.
    always_comb begin
        map_rc = 6'o77;
        fn_idx = 4'hF;
        case (code9)
            9'h01A: map_rc = 6'o01;
            9'h022: map_rc = 6'o02;
            9'h021: map_rc = 6'o03;
            9'h02A: map_rc = 6'o04;
            9'h01C: map_rc = 6'o10;
            9'h01B: map_rc = 6'o11;
            9'h023: map_rc = 6'o12;
            9'h02B: map_rc = 6'o13;
            9'h034: map_rc = 6'o14;
            9'h015: map_rc = 6'o20;
            9'h01D: map_rc = 6'o21;
            9'h024: map_rc = 6'o22;
            9'h02D: map_rc = 6'o23;
            9'h02C: map_rc = 6'o24;
            9'h016: map_rc = 6'o30;
            9'h01E: map_rc = 6'o31;
            9'h026: map_rc = 6'o32;
            9'h025: map_rc = 6'o33;
            9'h02E: map_rc = 6'o34;
            9'h045: map_rc = 6'o40;
            9'h046: map_rc = 6'o41;
            9'h03E: map_rc = 6'o42;
            9'h03D: map_rc = 6'o43;
            9'h036: map_rc = 6'o44;
            9'h04D: map_rc = 6'o50;
            9'h044: map_rc = 6'o51;
            9'h043: map_rc = 6'o52;
            9'h03C: map_rc = 6'o53;
            9'h035: map_rc = 6'o54;
            9'h04B: map_rc = 6'o61;
            9'h042: map_rc = 6'o62;
            9'h03B: map_rc = 6'o63;
            9'h033: map_rc = 6'o64;
            9'h029: map_rc = 6'o70;
            9'h03A: map_rc = 6'o72;
            9'h031: map_rc = 6'o73;
            9'h032: map_rc = 6'o74;
            default: ;
        endcase
        case (code9)
            9'h005: fn_idx = 4'd0;
            9'h006: fn_idx = 4'd1;
            9'h004: fn_idx = 4'd2;
            9'h00C: fn_idx = 4'd3;
            9'h003: fn_idx = 4'd4;
            9'h00B: fn_idx = 4'd5;
            9'h083: fn_idx = 4'd6;
            9'h00A: fn_idx = 4'd7;
            9'h001: fn_idx = 4'd8;
            9'h009: fn_idx = 4'd9;
            9'h078: fn_idx = 4'd10;
            default: ;
        endcase
    end

    // Prefix tracking and key state update on each received byte.
    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            ext_reg    <= 1'b0;
            rel_reg    <= 1'b0;
            matrix_reg <= '1;
            fn_reg     <= '0;
            hold_reg   <= '0;
`ifdef PS2_CURSOR_EN
            cur_reg    <= '0;
`endif
        end else if (byte_valid_reg) begin
            if (byte_reg == 8'hE0) begin
                ext_reg <= 1'b1;
            end else if (byte_reg == 8'hF0) begin
                rel_reg <= 1'b1;
            end else begin
                if (map_rc[2:0] != 3'd7) matrix_reg[map_rc[5:3]][map_rc[2:0]] <= rel_reg;
                if (fn_idx != 4'hF) fn_reg[fn_idx] <= ~rel_reg;
                case (code9)
                    9'h012: hold_reg[H_LSHIFT] <= ~rel_reg;
                    9'h059: hold_reg[H_RSHIFT] <= ~rel_reg;
                    9'h014: hold_reg[H_LCTRL]  <= ~rel_reg;
                    9'h114: hold_reg[H_RCTRL]  <= ~rel_reg;
                    9'h011: hold_reg[H_LALT]   <= ~rel_reg;
                    9'h111: hold_reg[H_RALT]   <= ~rel_reg;
                    9'h05A: hold_reg[H_ENTER]  <= ~rel_reg;
                    9'h15A: hold_reg[H_KPENT]  <= ~rel_reg;
`ifdef PS2_CURSOR_EN
                    9'h16B: cur_reg[0] <= ~rel_reg;
                    9'h172: cur_reg[1] <= ~rel_reg;
                    9'h175: cur_reg[2] <= ~rel_reg;
                    9'h174: cur_reg[3] <= ~rel_reg;
                    9'h066: cur_reg[4] <= ~rel_reg;
`endif
                    default: ;
                endcase
                rel_reg <= 1'b0;
                ext_reg <= 1'b0;
            end
        end
    end

    // Overlay the OR-combined keys onto the plain matrix.
    always_comb begin
        eff       = matrix_reg;
        eff[0][0] = ~(hold_reg[H_LSHIFT] | hold_reg[H_RSHIFT]);
        eff[6][0] = ~(hold_reg[H_ENTER]  | hold_reg[H_KPENT]);
        eff[7][1] = ~(hold_reg[H_LCTRL]  | hold_reg[H_RCTRL]);
`ifdef PS2_CURSOR_EN
        eff[0][0] = eff[0][0] & ~(|cur_reg);
        eff[3][4] = eff[3][4] & ~cur_reg[0];
        eff[4][4] = eff[4][4] & ~cur_reg[1];
        eff[4][3] = eff[4][3] & ~cur_reg[2];
        eff[4][2] = eff[4][2] & ~cur_reg[3];
        eff[4][0] = eff[4][0] & ~cur_reg[4];
`endif
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_row
            assign row_term[gi] = addr[8+gi] ? 5'h1F : eff[gi];
        end
    endgenerate

    // AND together every selected half-row.
    always_comb begin
        key_data = 5'h1F;
        for (int r = 0; r < 8; r++) key_data = key_data & row_term[r];
    end

    assign Fn  = fn_reg;
    assign mod = {hold_reg[H_LALT]   | hold_reg[H_RALT],
                  hold_reg[H_LCTRL]  | hold_reg[H_RCTRL],
                  hold_reg[H_LSHIFT] | hold_reg[H_RSHIFT]};

endmodule

// File: tb/tb_ps2_zx_keymatrix.sv
// Bench for ps2_zx_keymatrix: directed vector table, hand-written corner
// sequences (bad parity, watchdog, reset mid-frame) and randomized key events
// checked against a held-key reference model.
module tb_ps2_zx_keymatrix;

    logic        CLK = 1'b0;
    logic        nRESET = 1'b0;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic [15:0] addr = 16'hFFFF;
    logic [4:0]  key_data;
    logic [10:0] Fn;
    logic [2:0]  mod;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    ps2_zx_keymatrix #(.FILTER_LEN(8), .TIMEOUT_CYCLES(14000)) dut (
        .CLK(CLK), .nRESET(nRESET), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
        .addr(addr), .key_data(key_data), .Fn(Fn), .mod(mod)
    );

    typedef struct packed {
        logic [1:0]  n;
        logic [7:0]  b0, b1, b2;
        logic [15:0] a;
        logic [4:0]  kd;
        logic [10:0] fn;
        logic [2:0]  md;
    } vec_t;

    typedef struct packed {
        logic [8:0] code;
        logic [2:0] row;
        logic [2:0] col;
    } map_t;

    vec_t       vecs [26];
    map_t       map_q [$];
    logic [8:0] pool [$];
    logic [8:0] fcodes [11];
    bit         held [512];

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DAT = b;
        repeat (4) @(posedge CLK);
        PS2_CLK = 1'b0;
        repeat (12) @(posedge CLK);
        PS2_CLK = 1'b1;
        repeat (12) @(posedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad);
        logic p;
        p = ~(^d) ^ bad;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(p);
        ps2_bit(1'b1);
        repeat (4) @(posedge CLK);
    endtask

    task automatic send_key(input logic [8:0] code, input bit rel);
        if (code[8]) send_frame(8'hE0, 1'b0);
        if (rel) send_frame(8'hF0, 1'b0);
        send_frame(code[7:0], 1'b0);
    endtask

    task automatic add_row(input int r, input logic [8:0] c0, c1, c2, c3, c4);
        map_q.push_back({c0, 3'(r), 3'd0});
        map_q.push_back({c1, 3'(r), 3'd1});
        map_q.push_back({c2, 3'(r), 3'd2});
        map_q.push_back({c3, 3'(r), 3'd3});
        map_q.push_back({c4, 3'(r), 3'd4});
    endtask

    function automatic logic [4:0] model_kd(input logic [15:0] a);
        logic [4:0] k;
        k = 5'h1F;
        foreach (map_q[i])
            if (held[map_q[i].code] && !a[8 + map_q[i].row]) k[map_q[i].col] = 1'b0;
        return k;
    endfunction

    function automatic logic [10:0] model_fn();
        logic [10:0] f;
        for (int i = 0; i < 11; i++) f[i] = held[fcodes[i]];
        return f;
    endfunction

    function automatic logic [2:0] model_mod();
        return {held[9'h011] | held[9'h111], held[9'h014] | held[9'h114],
                held[9'h012] | held[9'h059]};
    endfunction

    task automatic settle_check(input string tag, input logic [15:0] a,
                                input logic [4:0] kd, input logic [10:0] fn, input logic [2:0] md);
        addr = a;
        @(negedge CLK);
        chk({tag, ".key_data"}, {11'd0, key_data}, {11'd0, kd});
        chk({tag, ".Fn"}, {5'd0, Fn}, {5'd0, fn});
        chk({tag, ".mod"}, {13'd0, mod}, {13'd0, md});
        $display("%s addr=%h key_data=%h Fn=%h mod=%h", tag, a, key_data, Fn, mod);
    endtask

    initial begin
        // Directed vectors: bytes to send, then addr and expected outputs.
        vecs[0]  = '{2'd0, 8'h00, 8'h00, 8'h00, 16'hFEFE, 5'h1F, 11'h000, 3'b000};
        vecs[1]  = '{2'd1, 8'h1C, 8'h00, 8'h00, 16'hFDFE, 5'h1E, 11'h000, 3'b000};
        vecs[2]  = '{2'd2, 8'hF0, 8'h1C, 8'h00, 16'hFDFE, 5'h1F, 11'h000, 3'b000};
        vecs[3]  = '{2'd1, 8'h12, 8'h00, 8'h00, 16'h00FE, 5'h1E, 11'h000, 3'b001};
        vecs[4]  = '{2'd1, 8'h1A, 8'h00, 8'h00, 16'h00FE, 5'h1C, 11'h000, 3'b001};
        vecs[5]  = '{2'd2, 8'hF0, 8'h12, 8'h00, 16'h00FE, 5'h1D, 11'h000, 3'b000};
        vecs[6]  = '{2'd2, 8'hF0, 8'h1A, 8'h00, 16'h00FE, 5'h1F, 11'h000, 3'b000};
        vecs[7]  = '{2'd1, 8'h59, 8'h00, 8'h00, 16'hFEFE, 5'h1E, 11'h000, 3'b001};
        vecs[8]  = '{2'd1, 8'h12, 8'h00, 8'h00, 16'hFEFE, 5'h1E, 11'h000, 3'b001};
        vecs[9]  = '{2'd2, 8'hF0, 8'h59, 8'h00, 16'hFEFE, 5'h1E, 11'h000, 3'b001};
        vecs[10] = '{2'd2, 8'hF0, 8'h12, 8'h00, 16'hFEFE, 5'h1F, 11'h000, 3'b000};
        vecs[11] = '{2'd2, 8'hE0, 8'h14, 8'h00, 16'h7FFE, 5'h1D, 11'h000, 3'b010};
        vecs[12] = '{2'd3, 8'hE0, 8'hF0, 8'h14, 16'h7FFE, 5'h1F, 11'h000, 3'b000};
        vecs[13] = '{2'd1, 8'h78, 8'h00, 8'h00, 16'hFFFE, 5'h1F, 11'h400, 3'b000};
        vecs[14] = '{2'd2, 8'hF0, 8'h78, 8'h00, 16'hFFFE, 5'h1F, 11'h000, 3'b000};
        vecs[15] = '{2'd2, 8'hE0, 8'h5A, 8'h00, 16'hBFFE, 5'h1E, 11'h000, 3'b000};
        vecs[16] = '{2'd3, 8'hE0, 8'hF0, 8'h5A, 16'hBFFE, 5'h1F, 11'h000, 3'b000};
        vecs[17] = '{2'd1, 8'h83, 8'h00, 8'h00, 16'hFFFE, 5'h1F, 11'h040, 3'b000};
        vecs[18] = '{2'd2, 8'hF0, 8'h83, 8'h00, 16'hFFFE, 5'h1F, 11'h000, 3'b000};
        vecs[19] = '{2'd1, 8'h45, 8'h00, 8'h00, 16'hEFFE, 5'h1E, 11'h000, 3'b000};
        vecs[20] = '{2'd2, 8'hF0, 8'h45, 8'h00, 16'hEFFE, 5'h1F, 11'h000, 3'b000};
        vecs[21] = '{2'd1, 8'h36, 8'h00, 8'h00, 16'h0000, 5'h0F, 11'h000, 3'b000};
        vecs[22] = '{2'd2, 8'hF0, 8'h36, 8'h00, 16'h0000, 5'h1F, 11'h000, 3'b000};
        vecs[23] = '{2'd2, 8'hE0, 8'h1C, 8'h00, 16'hFDFE, 5'h1F, 11'h000, 3'b000};
        vecs[24] = '{2'd1, 8'h1C, 8'h00, 8'h00, 16'hFFFF, 5'h1F, 11'h000, 3'b000};
        vecs[25] = '{2'd2, 8'hF0, 8'h1C, 8'h00, 16'hFDFE, 5'h1F, 11'h000, 3'b000};

        // Reference key layout for the random phase.
        add_row(0, 9'h012, 9'h01A, 9'h022, 9'h021, 9'h02A);
        add_row(1, 9'h01C, 9'h01B, 9'h023, 9'h02B, 9'h034);
        add_row(2, 9'h015, 9'h01D, 9'h024, 9'h02D, 9'h02C);
        add_row(3, 9'h016, 9'h01E, 9'h026, 9'h025, 9'h02E);
        add_row(4, 9'h045, 9'h046, 9'h03E, 9'h03D, 9'h036);
        add_row(5, 9'h04D, 9'h044, 9'h043, 9'h03C, 9'h035);
        add_row(6, 9'h05A, 9'h04B, 9'h042, 9'h03B, 9'h033);
        add_row(7, 9'h029, 9'h014, 9'h03A, 9'h031, 9'h032);
        map_q.push_back({9'h059, 3'd0, 3'd0});
        map_q.push_back({9'h15A, 3'd6, 3'd0});
        map_q.push_back({9'h114, 3'd7, 3'd1});
`ifdef PS2_CURSOR_EN
        map_q.push_back({9'h16B, 3'd0, 3'd0}); map_q.push_back({9'h16B, 3'd3, 3'd4});
        map_q.push_back({9'h172, 3'd0, 3'd0}); map_q.push_back({9'h172, 3'd4, 3'd4});
        map_q.push_back({9'h175, 3'd0, 3'd0}); map_q.push_back({9'h175, 3'd4, 3'd3});
        map_q.push_back({9'h174, 3'd0, 3'd0}); map_q.push_back({9'h174, 3'd4, 3'd2});
        map_q.push_back({9'h066, 3'd0, 3'd0}); map_q.push_back({9'h066, 3'd4, 3'd0});
`endif
        fcodes = '{9'h005, 9'h006, 9'h004, 9'h00C, 9'h003, 9'h00B,
                   9'h083, 9'h00A, 9'h001, 9'h009, 9'h078};
        foreach (map_q[i]) pool.push_back(map_q[i].code);
        foreach (fcodes[i]) pool.push_back(fcodes[i]);
        pool.push_back(9'h011); pool.push_back(9'h111);
        pool.push_back(9'h00E); pool.push_back(9'h05D); pool.push_back(9'h112);
        pool.push_back(9'h16B); pool.push_back(9'h172); pool.push_back(9'h175);
        pool.push_back(9'h174); pool.push_back(9'h066);

        // Reset.
        nRESET = 1'b0;
        repeat (5) @(posedge CLK);
        nRESET = 1'b1;
        repeat (2) @(posedge CLK);

        // Directed table.
        for (int i = 0; i < 26; i++) begin
            if (vecs[i].n > 0) send_frame(vecs[i].b0, 1'b0);
            if (vecs[i].n > 1) send_frame(vecs[i].b1, 1'b0);
            if (vecs[i].n > 2) send_frame(vecs[i].b2, 1'b0);
            settle_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].kd, vecs[i].fn, vecs[i].md);
        end

        // Bad parity frame is dropped; the next good one is accepted.
        send_frame(8'h29, 1'b1);
        settle_check("badpar", 16'h7FFE, 5'h1F, 11'h000, 3'b000);
        send_frame(8'h29, 1'b0);
        settle_check("goodpar", 16'h7FFE, 5'h1E, 11'h000, 3'b000);
        send_key(9'h029, 1'b1);
        settle_check("space_rel", 16'h7FFE, 5'h1F, 11'h000, 3'b000);

        // Stalled frame must be abandoned by the watchdog.
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        repeat (14010) @(posedge CLK);
        send_frame(8'h05, 1'b0);
        settle_check("timeout_f1", 16'hFFFF, 5'h1F, 11'h001, 3'b000);
        send_key(9'h005, 1'b1);
        settle_check("f1_rel", 16'hFFFF, 5'h1F, 11'h000, 3'b000);

        // Reset mid-frame clears the matrix, the pending release and the frame.
        send_frame(8'h1C, 1'b0);
        settle_check("a_hold", 16'hFDFE, 5'h1E, 11'h000, 3'b000);
        send_frame(8'hF0, 1'b0);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
        @(posedge CLK); nRESET = 1'b0;
        repeat (2) @(posedge CLK); nRESET = 1'b1;
        repeat (20) @(posedge CLK);
        settle_check("midrst", 16'hFDFE, 5'h1F, 11'h000, 3'b000);
        send_frame(8'h1C, 1'b0);
        settle_check("after_rst", 16'hFDFE, 5'h1E, 11'h000, 3'b000);
        send_key(9'h01C, 1'b1);
        settle_check("after_rst_rel", 16'hFDFE, 5'h1F, 11'h000, 3'b000);

`ifdef PS2_CURSOR_EN
        // Cursor up = CAPS SHIFT + 7; shift physically held survives arrow release.
        send_key(9'h175, 1'b0);
        settle_check("up_r4", 16'hEFFE, 5'h17, 11'h000, 3'b000);
        settle_check("up_r0", 16'hFEFE, 5'h1E, 11'h000, 3'b000);
        send_key(9'h012, 1'b0);
        send_key(9'h175, 1'b1);
        settle_check("uprel_r4", 16'hEFFE, 5'h1F, 11'h000, 3'b001);
        settle_check("uprel_r0", 16'hFEFE, 5'h1E, 11'h000, 3'b001);
        send_key(9'h012, 1'b1);
        settle_check("shift_rel", 16'hFEFE, 5'h1F, 11'h000, 3'b000);
`endif

        // Randomized key events against the held-key model.
        foreach (held[i]) held[i] = 1'b0;
        for (int e = 0; e < 30; e++) begin
            logic [8:0]  code;
            bit          rel;
            logic [15:0] a;
            code = pool[$urandom_range(0, pool.size() - 1)];
            rel  = held[code] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
            send_key(code, rel);
            held[code] = !rel;
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 3))
                    0: a = 16'($urandom);
                    1: a = {~(8'h01 << $urandom_range(0, 7)), 8'hFE};
                    2: a = 16'h00FE;
                    default: a = {8'($urandom), 8'hFE};
                endcase
                settle_check($sformatf("rnd%0d.%0d code=%h rel=%0d", e, k, code, rel),
                             a, model_kd(a), model_fn(), model_mod());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
